// File: rtl/vibrometer_pkg.sv
// Shared types and helpers for the vibrometer velocity path: FSM states,
// window clamp and the wrap-aware position difference.
package vibrometer_pkg;

  typedef enum logic {PRIME, RUN} ve_state_e;

  localparam int VE_MAX_LOG_WINDOW = 16;

  // Position wraps modulo 2^16, so the raw difference read as signed is the true step.
  function automatic logic signed [15:0] pos_delta(input logic [15:0] cur,
                                                   input logic [15:0] prev);
    logic [15:0] diff;
    diff = cur - prev;
    return signed'(diff);
  endfunction

  function automatic logic [4:0] clamp_log(input logic [4:0] k);
    return (k > 5'(VE_MAX_LOG_WINDOW)) ? 5'(VE_MAX_LOG_WINDOW) : k;
  endfunction

endpackage

// File: rtl/axis_output_holder.sv
// Single-entry AXI4-Stream output register; a load while a word is still
// pending overwrites it and raises a one-cycle overrun pulse.
module axis_output_holder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              tready_i,
  output logic              tvalid_o,
  output logic [DATA_W-1:0] tdata_o,
  output logic              overrun_o
);

  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    if (load_i) begin
      tvalid_d = 1'b1;
      tdata_d  = data_i;
    end else if (tvalid_q && tready_i) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  // A load coinciding with a completed transfer is a clean hand-off, not an overrun.
  assign overrun_o = load_i && tvalid_q && !tready_i;
  assign tvalid_o  = tvalid_q;
  assign tdata_o   = tdata_q;

endmodule

// File: rtl/axis_velocity_estimator.sv
// Sums wrap-aware position deltas over 2^k samples and emits one signed
// velocity word per window on an AXI4-Stream master.
module axis_velocity_estimator
  import vibrometer_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 16,
  parameter int M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [4:0]                    VE_log_window,
  input  logic                          VE_clear,
  output logic                          VE_overrun,
  input  logic                          S_AXIS_tvalid,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic                          S_AXIS_tready,
  input  logic                          M_AXIS_tready,
  output logic                          M_AXIS_tvalid,
  output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata
);

  ve_state_e                              state_q, state_d;
  logic        [S_AXIS_TDATA_WIDTH-1:0]   prev_q, prev_d;
  logic signed [M_AXIS_TDATA_WIDTH-1:0]   acc_q, acc_d;
  logic        [16:0]                     cnt_q, cnt_d;
  logic        [4:0]                      k_lat_q, k_lat_d;
  logic                                   overrun_q, overrun_d;

  logic signed [15:0]                     delta_p0;
  logic signed [M_AXIS_TDATA_WIDTH-1:0]   delta_ext_p0;
  logic signed [M_AXIS_TDATA_WIDTH-1:0]   sum_p0;
  logic                                   win_last;
  logic                                   load;
  logic                                   overrun_pulse;

  assign S_AXIS_tready = 1'b1;

  assign delta_p0     = pos_delta(S_AXIS_tdata, prev_q);
  assign delta_ext_p0 = {{(M_AXIS_TDATA_WIDTH-16){delta_p0[15]}}, delta_p0};
  assign sum_p0       = acc_q + delta_ext_p0;
  assign win_last     = (cnt_q == ((17'd1 << k_lat_q) - 17'd1));

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_lat_d = k_lat_q;
    load    = 1'b0;
    case (state_q)
      PRIME: begin
        if (S_AXIS_tvalid) begin
          prev_d  = S_AXIS_tdata;
          acc_d   = '0;
          cnt_d   = '0;
          k_lat_d = clamp_log(VE_log_window);
          state_d = RUN;
        end
      end
      RUN: begin
        if (S_AXIS_tvalid) begin
          prev_d = S_AXIS_tdata;
          // Window size only changes at a boundary so a window is never split.
          if (win_last) begin
            load    = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            k_lat_d = clamp_log(VE_log_window);
          end else begin
            acc_d = sum_p0;
            cnt_d = cnt_q + 17'd1;
          end
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_pulse)  overrun_d = 1'b1;
    else if (VE_clear)  overrun_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= PRIME;
      prev_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      k_lat_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      k_lat_q   <= k_lat_d;
      overrun_q <= overrun_d;
    end
  end

  axis_output_holder #(
    .DATA_W(M_AXIS_TDATA_WIDTH)
  ) u_holder (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load_i   (load),
    .data_i   (sum_p0),
    .tready_i (M_AXIS_tready),
    .tvalid_o (M_AXIS_tvalid),
    .tdata_o  (M_AXIS_tdata),
    .overrun_o(overrun_pulse)
  );

  assign VE_overrun = overrun_q;

endmodule

// File: doc/axis_velocity_estimator.md
Name: axis_velocity_estimator

Overview:
- Downstream neighbour of the fringe-counting position tracker. Consumes its 16-bit signed, wrapping position stream.
- Accumulates wrap-aware per-sample position deltas over a programmable window of 2^k samples.
- Emits one signed 32-bit velocity word per window on an AXI4-Stream master, with an output holding register and sticky overrun detection.

Parameters:
- S_AXIS_TDATA_WIDTH, 16: width of the incoming position word (signed, two's complement, wraps).
- M_AXIS_TDATA_WIDTH, 32: width of the outgoing velocity word (signed).

Ports:
- aclk  in  1  system clock; all logic on rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- VE_log_window  in  5  window exponent k; window = 2^k samples; values >16 clamp to 16.
- VE_clear  in  1  one-cycle pulse; clears VE_overrun.
- VE_overrun  out  1  sticky flag: a completed window overwrote an unconsumed output.
- S_AXIS_tvalid  in  1  input sample valid.
- S_AXIS_tdata  in  S_AXIS_TDATA_WIDTH  position sample.
- S_AXIS_tready  out  1  constant 1; block never back-pressures upstream.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  velocity word valid.
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  velocity = sum of deltas over the window.

Behaviour:
- Reset (aresetn=0, asynchronous): state=PRIME, prev=0, acc=0, cnt=0, k_lat=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, VE_overrun=0.
- Sample accepted when S_AXIS_tvalid=1; tready is tied high.
- State PRIME:
  - First accepted sample: prev<=sample, acc<=0, cnt<=0, k_lat<=min(VE_log_window,16).
  - Go to RUN. No output is produced.
- State RUN, per accepted sample:
  - delta = (sample - prev) computed modulo 2^16 and read as signed 16-bit. Example: 32767 -> -32768 gives +1.
  - delta is sign-extended to 32 bits; prev<=sample.
- Window not complete (cnt != 2^k_lat - 1): acc<=acc+delta, cnt<=cnt+1.
- Window complete (cnt == 2^k_lat - 1):
  - M_AXIS_tdata<=acc+delta; M_AXIS_tvalid<=1.
  - acc<=0, cnt<=0.
  - k_lat<=min(VE_log_window,16), so window-size changes take effect only at window boundaries.
- Latency: tvalid asserts the cycle after the last window sample is accepted.
- k_lat=0: every sample produces one output equal to its delta.
- Width rule: |delta| <= 2^15 and the window is at most 2^16 samples, so the 32-bit sum cannot overflow. Counter is 17 bits.
- Output handshake: the transfer completes when tvalid & tready. tvalid then drops the next cycle unless a new window completes in that same cycle.
- Simultaneous transfer and window completion: new word loaded, tvalid stays 1, no overrun.
- Overrun: window completes while tvalid=1 and tready=0.
  - The new word overwrites tdata and tvalid stays 1.
  - VE_overrun<=1 (sticky).
- VE_clear: clears VE_overrun. If an overrun occurs in the same cycle, the set wins.
- tdata is stable while tvalid=1 & tready=0, except on overrun.
- Reset mid-window: partial accumulation is discarded and any pending output is dropped. The block re-primes on the next sample.

Decomposition:
- Shared package vibrometer_pkg:
  - state enum (PRIME, RUN);
  - constant VE_MAX_LOG_WINDOW=16;
  - function for the signed modular 16-bit difference.
- One natural sub-module: axis_output_holder. It is a single-entry output register with a load/overwrite input, the tvalid/tready handshake, and an overrun pulse output. The top level keeps the prime/accumulate/count logic.

Test Plan:
- k=2, samples 0,1,3,6,10 with no backpressure -> no output for prime sample 0; one word 10 (1+2+3+4) the cycle after sample 10; VE_overrun=0.
- k=0, samples 32766,32767,-32768,-32767 -> outputs +1,+1,+1 (wrap handled); no glitch at the wrap.
- k=1, tready=0, samples 0,5,10,15,20 -> first word 10, overwritten by 10 again; VE_overrun=1. Raise tready -> one transfer, then tvalid=0. VE_clear pulse -> VE_overrun=0.
- k=31, constant increments of +2 for 65537 samples -> clamped to 16; single output 131072.
- VE_log_window changed from 2 to 0 mid-window -> current window still completes after 4 samples; afterwards one output per sample.
- aresetn asserted asynchronously mid-window while tvalid=1 -> all outputs 0 immediately. After release, the first sample primes; the next full window gives the correct sum.
